// File: rtl/ace_pkg.sv
// Shared types for the CCU snoop scheduler.
// Holds the admission FSM encoding.
package ace_pkg;

  typedef enum logic {
    RUN,
    DRAIN
  } ccu_sched_state_e;

endpackage

// File: rtl/ace_ccu_snoop_credit.sv
// Per-initiator snoop slot: registered select mask,
// in-flight credit counter, bypass pulse, error detect.
module ace_ccu_snoop_credit
  import ace_pkg::*;
#(
  parameter int unsigned NumOup         = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              run_i,
  input  logic [NumOup-1:0] mask_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  output logic [NumOup-1:0] sel_o,
  output logic              sel_valid_o,
  input  logic              sel_ready_i,
  input  logic              done_i,
  output logic              bypass_o,
  output logic [CntW-1:0]   cnt_o,
  output logic              err_o
);

  logic accept;
  logic issue;
  logic dec;
  logic empty;

  assign empty = (cnt_o == '0);

  assign req_ready_o = run_i
                    && (cnt_o < CntW'(MaxOutstanding))
                    && (!sel_valid_o || sel_ready_i);

  assign accept = req_valid_i & req_ready_o;
  assign issue  = accept & (|mask_i);
  assign dec    = done_i & ~empty;
  assign err_o  = done_i & empty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sel_o       <= '0;
      sel_valid_o <= 1'b0;
      bypass_o    <= 1'b0;
      cnt_o       <= '0;
    end else begin
      if (issue) begin
        sel_o <= mask_i;
      end
      // a fresh issue reloads the slot even as the old mask is taken
      if (issue) begin
        sel_valid_o <= 1'b1;
      end else if (sel_ready_i) begin
        sel_valid_o <= 1'b0;
      end
      bypass_o <= accept & ~(|mask_i);
      if (issue && !dec) begin
        cnt_o <= cnt_o + CntW'(1);
      end else if (dec && !issue) begin
        cnt_o <= cnt_o - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/ace_ccu_snoop_sched.sv
// CCU snoop admission controller: per-input credit slots
// plus a drain-then-apply coherent mask reconfiguration FSM.
module ace_ccu_snoop_sched
  import ace_pkg::*;
#(
  parameter int unsigned       NumInp         = 4,
  parameter int unsigned       NumOup         = 4,
  parameter int unsigned       MaxOutstanding = 4,
  parameter bit                ExcludeSelf    = 1'b1,
  parameter logic [NumOup-1:0] ResetMask      = '1,
  localparam int unsigned      CntW = $clog2(MaxOutstanding + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumInp-1:0]            req_valid_i,
  output logic [NumInp-1:0]            req_ready_o,
  output logic [NumInp-1:0][NumOup-1:0] sel_o,
  output logic [NumInp-1:0]            sel_valid_o,
  input  logic [NumInp-1:0]            sel_ready_i,
  input  logic [NumInp-1:0]            done_i,
  output logic [NumInp-1:0]            bypass_o,
  input  logic [NumOup-1:0]            cfg_mask_i,
  input  logic                         cfg_valid_i,
  output logic                         cfg_ready_o,
  output logic [NumOup-1:0]            active_mask_o,
  output logic [NumInp-1:0][CntW-1:0]  cnt_o,
  output logic                         err_o
);

  ccu_sched_state_e state_q;
  ccu_sched_state_e state_d;

  logic              run;
  logic              all_zero;
  logic [NumInp-1:0] err_pulse;

  // gate with reset so no request is admitted while held in reset
  assign run         = (state_q == RUN) && !rst_i;
  assign all_zero    = (cnt_o == '0);
  assign cfg_ready_o = (state_q == DRAIN) && all_zero;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (cfg_valid_i) state_d = DRAIN;
      DRAIN:   if (all_zero) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= RUN;
      active_mask_o <= ResetMask;
      err_o         <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cfg_ready_o && cfg_valid_i) begin
        active_mask_o <= cfg_mask_i;
      end
      if (|err_pulse) begin
        err_o <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NumInp; i++) begin : g_inp
    logic [NumOup-1:0] excl;
    logic [NumOup-1:0] mask;

    assign excl = ExcludeSelf ? (NumOup'(1) << i) : '0;
    assign mask = active_mask_o & ~excl;

    ace_ccu_snoop_credit #(
      .NumOup         (NumOup),
      .MaxOutstanding (MaxOutstanding),
      .CntW           (CntW)
    ) u_credit (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .run_i       (run),
      .mask_i      (mask),
      .req_valid_i (req_valid_i[i]),
      .req_ready_o (req_ready_o[i]),
      .sel_o       (sel_o[i]),
      .sel_valid_o (sel_valid_o[i]),
      .sel_ready_i (sel_ready_i[i]),
      .done_i      (done_i[i]),
      .bypass_o    (bypass_o[i]),
      .cnt_o       (cnt_o[i]),
      .err_o       (err_pulse[i])
    );
  end

endmodule
